// File: rtl/fifo_pkg.sv
// Shared defaults so sync_fifo and its read-side drain stage agree on
// geometry, plus the occupancy type used by the drain stage's credit logic.
package fifo_pkg;

  localparam int WIDTH     = 8;
  localparam int DEPTH     = 16;
  localparam int PTR_WIDTH = $clog2(DEPTH);
  localparam int CNT_WIDTH = 16;

  // Occupancy of the 2-entry output buffer (0..2).
  typedef logic [1:0] occ_t;

endpackage

// File: rtl/stream_buf2.sv
// Two-entry register FIFO: head holds the word on the output, tail holds the
// word that follows it. Push and pop may happen in the same cycle.
module stream_buf2
  import fifo_pkg::*;
#(
  parameter int WIDTH = fifo_pkg::WIDTH
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             push_i,
  input  logic [WIDTH-1:0] push_data_i,
  input  logic             pop_i,
  output logic             valid_o,
  output logic [WIDTH-1:0] data_o,
  output occ_t             count_o
);

  // Handshake: the owner only asserts pop_i while valid_o=1, and only asserts
  // push_i when a free slot exists after this cycle's pop.
  logic [WIDTH-1:0] head;
  logic [WIDTH-1:0] tail;
  occ_t             count;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      head  <= '0;
      tail  <= '0;
      count <= 2'd0;
    end else begin
      case (count)
        2'd0: begin
          if (push_i) begin
            head  <= push_data_i;
            count <= 2'd1;
          end
        end
        2'd1: begin
          if (push_i && pop_i) begin
            head <= push_data_i;
          end else if (push_i) begin
            tail  <= push_data_i;
            count <= 2'd2;
          end else if (pop_i) begin
            count <= 2'd0;
          end
        end
        default: begin
          // Full: the tail moves up on a pop; a simultaneous push refills it.
          if (pop_i) begin
            head <= tail;
            if (push_i) tail <= push_data_i;
            else        count <= 2'd1;
          end
        end
      endcase
    end
  end

  assign valid_o = (count != 2'd0);
  assign data_o  = head;
  assign count_o = count;

endmodule

// File: rtl/fifo_stream_drain.sv
// Read-side drain for sync_fifo: issues FIFO reads against a 2-word credit
// (buffered + in-flight) and presents the words on a valid/ready stream.
module fifo_stream_drain
  import fifo_pkg::*;
#(
  parameter int WIDTH     = fifo_pkg::WIDTH,
  parameter int CNT_WIDTH = fifo_pkg::CNT_WIDTH
) (
  input  logic                 clk_i,
  input  logic                 rst_i,
  input  logic                 fifo_empty_i,
  input  logic [WIDTH-1:0]     fifo_rd_data_i,
  output logic                 fifo_rd_en_o,
  output logic                 m_valid_o,
  output logic [WIDTH-1:0]     m_data_o,
  input  logic                 m_ready_i,
  output logic [CNT_WIDTH-1:0] beat_cnt_o
);

  // Stream handshake: a beat transfers when m_valid_o & m_ready_i at a rising
  // edge; m_valid_o/m_data_o are registered and hold until that transfer.
  logic       inflight;
  logic       pop;
  occ_t       buf_count;
  logic [2:0] used;

  assign pop  = m_valid_o & m_ready_i;
  assign used = {1'b0, buf_count} + {2'b00, inflight} - {2'b00, pop};

  // A read is only issued if its word is guaranteed a slot when it lands.
  assign fifo_rd_en_o = ~rst_i & ~fifo_empty_i & (used < 3'd2);

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      inflight   <= 1'b0;
      beat_cnt_o <= '0;
    end else begin
      inflight <= fifo_rd_en_o;
      if (pop) beat_cnt_o <= beat_cnt_o + {{(CNT_WIDTH-1){1'b0}}, 1'b1};
    end
  end

  stream_buf2 #(
    .WIDTH (WIDTH)
  ) u_buf (
    .clk_i       (clk_i),
    .rst_i       (rst_i),
    .push_i      (inflight),
    .push_data_i (fifo_rd_data_i),
    .pop_i       (pop),
    .valid_o     (m_valid_o),
    .data_o      (m_data_o),
    .count_o     (buf_count)
  );

endmodule

// File: tb/tb_fifo_stream_drain.sv
// Bench for fifo_stream_drain: behavioural sync_fifo model, stream scoreboard
// and per-scenario tasks run in sequence.
module tb_fifo_stream_drain;

  localparam int W  = 8;
  localparam int CW = 4;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic          fifo_empty = 1'b1;
  logic [W-1:0]  fifo_rd_data = '0;
  logic          fifo_rd_en;
  logic          m_valid;
  logic [W-1:0]  m_data;
  logic          m_ready = 1'b0;
  logic [CW-1:0] beat_cnt;

  logic          wr_en = 1'b0;
  logic [W-1:0]  wr_data = '0;

  logic [W-1:0]  fifo_q[$];
  logic [W-1:0]  exp_q[$];

  int total = 0;
  int bad = 0;
  int rd_issued = 0;
  int beats = 0;
  bit started = 0;
  bit rd_err = 0;

  logic          inflight_m = 1'b0;
  int            occ_buf = 0;
  logic [CW-1:0] beat_exp = '0;
  bit            hold_prev = 0;
  logic [W-1:0]  data_prev = '0;
  logic [W-1:0]  exp_word;

  fifo_stream_drain #(
    .WIDTH     (W),
    .CNT_WIDTH (CW)
  ) dut (
    .clk_i          (clk),
    .rst_i          (rst),
    .fifo_empty_i   (fifo_empty),
    .fifo_rd_data_i (fifo_rd_data),
    .fifo_rd_en_o   (fifo_rd_en),
    .m_valid_o      (m_valid),
    .m_data_o       (m_data),
    .m_ready_i      (m_ready),
    .beat_cnt_o     (beat_cnt)
  );

  // ---------------- sync_fifo model and occupancy model ----------------
  always @(posedge clk) begin
    if (rst) begin
      fifo_q.delete();
      if (wr_en) fifo_q.push_back(wr_data);
      fifo_empty <= !wr_en;
      inflight_m <= 1'b0;
      occ_buf    <= 0;
      beat_exp   <= '0;
    end else begin
      if (fifo_rd_en && fifo_empty) rd_err = 1;
      if (fifo_rd_en && !fifo_empty) begin
        fifo_rd_data <= fifo_q.pop_front();
        rd_issued++;
      end
      if (wr_en) fifo_q.push_back(wr_data);
      fifo_empty <= (fifo_q.size() == 0);
      inflight_m <= fifo_rd_en & ~fifo_empty;
      occ_buf    <= occ_buf + int'(inflight_m) - int'(m_valid & m_ready);
      if (m_valid && m_ready) begin
        beat_exp <= beat_exp + 1'b1;
        beats++;
      end
    end
  end

  // ---------------- scoreboard / stream monitor ----------------
  always @(negedge clk) begin
    if (started && !rst) begin
      total++;
      if (fifo_rd_en && fifo_empty) begin
        bad++; $display("FAIL rd_while_empty t=%0t rd_en=%b empty=%b", $time, fifo_rd_en, fifo_empty);
      end
      total++;
      if (m_valid !== (occ_buf != 0)) begin
        bad++; $display("FAIL valid_vs_occupancy t=%0t got=%b want=%b", $time, m_valid, occ_buf != 0);
      end
      total++;
      if (occ_buf > 2) begin
        bad++; $display("FAIL occupancy_over_2 t=%0t got=%0d want<=2", $time, occ_buf);
      end
      total++;
      if (beat_cnt !== beat_exp) begin
        bad++; $display("FAIL beat_cnt t=%0t got=%0d want=%0d", $time, beat_cnt, beat_exp);
      end
      if (hold_prev) begin
        total++;
        if (m_valid !== 1'b1 || m_data !== data_prev) begin
          bad++; $display("FAIL hold_stable t=%0t got=%b/%h want=1/%h", $time, m_valid, m_data, data_prev);
        end
      end
      if (m_valid && m_ready) begin
        total++;
        if (exp_q.size() == 0) begin
          bad++; $display("FAIL unexpected_beat t=%0t got=%h want=none", $time, m_data);
        end else begin
          exp_word = exp_q.pop_front();
          if (m_data !== exp_word) begin
            bad++; $display("FAIL beat_data t=%0t got=%h want=%h", $time, m_data, exp_word);
          end
        end
      end
      hold_prev = m_valid && !m_ready;
      data_prev = m_data;
    end else begin
      hold_prev = 0;
    end
  end

  // ---------------- driver tasks ----------------
  task automatic write_words(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk); #1;
      wr_en   = 1'b1;
      wr_data = W'($urandom_range(0, 255));
      exp_q.push_back(wr_data);
    end
    @(posedge clk); #1;
    wr_en = 1'b0;
  endtask

  task automatic do_reset();
    @(posedge clk); #1;
    rst   = 1'b1;
    wr_en = 1'b0;
    exp_q.delete();
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
  endtask

  task automatic wait_drain(input int budget);
    int i;
    i = 0;
    while (i < budget && (exp_q.size() != 0 || m_valid === 1'b1)) begin
      @(negedge clk);
      i++;
    end
    total++;
    if (i >= budget) begin
      bad++; $display("FAIL drain_timeout left=%0d want=0", exp_q.size());
    end
  endtask

  // ---------------- scenarios ----------------
  task automatic test_reset();
    rst = 1'b1; m_ready = 1'b1; wr_en = 1'b1; wr_data = 8'hA5;
    @(negedge clk);
    total++;
    if (fifo_rd_en !== 1'b0) begin bad++; $display("FAIL reset_rd_en0 got=%b want=0", fifo_rd_en); end
    @(posedge clk); #1 wr_data = 8'h3C;
    @(negedge clk);
    total++;
    if (fifo_rd_en !== 1'b0 || m_valid !== 1'b0 || m_data !== '0 || beat_cnt !== '0) begin
      bad++; $display("FAIL reset_outputs got=%b/%b/%h/%0d want=0/0/00/0", fifo_rd_en, m_valid, m_data, beat_cnt);
    end
    @(posedge clk); #1;
    rst = 1'b0; wr_en = 1'b0;
    exp_q.delete(); exp_q.push_back(8'h3C);
    started = 1;
    @(negedge clk);
    total++;
    if (fifo_rd_en !== 1'b1) begin bad++; $display("FAIL reset_first_read got=%b want=1", fifo_rd_en); end
    wait_drain(20);
    total++;
    if (beat_cnt !== 4'd1) begin bad++; $display("FAIL reset_beat got=%0d want=1", beat_cnt); end
  endtask

  task automatic test_streaming();
    int t_empty, t_valid, first, last, nb;
    do_reset();
    m_ready = 1'b1;
    t_empty = -1; t_valid = -1; first = -1; last = -1; nb = 0;
    fork
      write_words(16);
      for (int i = 0; i < 60; i++) begin
        @(negedge clk);
        if (t_empty < 0 && !fifo_empty) begin
          t_empty = i;
          total++;
          if (fifo_rd_en !== 1'b1) begin bad++; $display("FAIL stream_rd_same_cycle got=%b want=1", fifo_rd_en); end
        end
        if (t_valid < 0 && m_valid === 1'b1) t_valid = i;
        if (m_valid === 1'b1 && m_ready) begin
          if (first < 0) first = i;
          last = i; nb++;
        end
      end
    join
    total++;
    if (t_valid - t_empty != 2) begin bad++; $display("FAIL stream_latency got=%0d want=2", t_valid - t_empty); end
    total++;
    if (nb != 16 || last - first != 15) begin
      bad++; $display("FAIL stream_back_to_back got=%0d beats over %0d cycles want=16 over 16", nb, last - first + 1);
    end
    total++;
    if (beat_cnt !== 4'(16)) begin bad++; $display("FAIL stream_beat got=%0d want=0", beat_cnt); end
  endtask

  task automatic test_back_pressure();
    bit pat[4];
    int b0;
    pat = '{1'b1, 1'b0, 1'b0, 1'b1};
    do_reset();
    b0 = beats;
    m_ready = 1'b0;
    write_words(16);
    for (int i = 0; i < 200 && exp_q.size() != 0; i++) begin
      @(posedge clk); #1;
      m_ready = pat[i % 4];
    end
    m_ready = 1'b1;
    wait_drain(20);
    total++;
    if (beats - b0 != 16) begin bad++; $display("FAIL bp_beats got=%0d want=16", beats - b0); end
  endtask

  task automatic test_stall_release();
    int r0, first, last, nb;
    do_reset();
    m_ready = 1'b0;
    r0 = rd_issued;
    write_words(11);
    repeat (10) @(posedge clk);
    @(negedge clk);
    total++;
    if (rd_issued - r0 != 2) begin bad++; $display("FAIL stall_reads got=%0d want=2", rd_issued - r0); end
    first = -1; last = -1; nb = 0;
    @(posedge clk); #1 m_ready = 1'b1;
    for (int i = 0; i < 30; i++) begin
      @(negedge clk);
      if (m_valid === 1'b1) begin
        if (first < 0) first = i;
        last = i; nb++;
      end
    end
    total++;
    if (nb != 11 || last - first != 10 || first != 0) begin
      bad++; $display("FAIL stall_release got=%0d beats first=%0d last=%0d want=11 first=0 last=10", nb, first, last);
    end
  endtask

  task automatic test_drain();
    int b0;
    do_reset();
    m_ready = 1'b1;
    b0 = beats;
    write_words(3);
    wait_drain(30);
    repeat (3) @(negedge clk);
    total++;
    if (m_valid !== 1'b0 || fifo_rd_en !== 1'b0 || fifo_empty !== 1'b1) begin
      bad++; $display("FAIL drain_idle got=%b/%b/%b want=0/0/1", m_valid, fifo_rd_en, fifo_empty);
    end
    total++;
    if (beats - b0 != 3 || beat_cnt !== 4'd3) begin
      bad++; $display("FAIL drain_beats got=%0d/%0d want=3/3", beats - b0, beat_cnt);
    end
  endtask

  task automatic test_reset_mid();
    do_reset();
    m_ready = 1'b0;
    write_words(6);
    repeat (4) @(posedge clk);
    @(negedge clk);
    total++;
    if (m_valid !== 1'b1 || occ_buf != 2) begin
      bad++; $display("FAIL mid_full got=%b/%0d want=1/2", m_valid, occ_buf);
    end
    @(posedge clk); #1;
    rst = 1'b1;
    exp_q.delete();
    @(posedge clk);
    @(negedge clk);
    total++;
    if (fifo_rd_en !== 1'b0 || m_valid !== 1'b0 || m_data !== '0 || beat_cnt !== '0) begin
      bad++; $display("FAIL mid_reset_clear got=%b/%b/%h/%0d want=0/0/00/0", fifo_rd_en, m_valid, m_data, beat_cnt);
    end
    @(posedge clk); #1;
    rst = 1'b0;
    m_ready = 1'b1;
    write_words(4);
    wait_drain(30);
    total++;
    if (beat_cnt !== 4'd4) begin bad++; $display("FAIL mid_post_beats got=%0d want=4", beat_cnt); end
  endtask

  task automatic test_wrap();
    do_reset();
    m_ready = 1'b1;
    write_words(17);
    wait_drain(40);
    total++;
    if (beat_cnt !== 4'd1) begin bad++; $display("FAIL wrap_beat got=%0d want=1", beat_cnt); end
  endtask

  // ---------------- sequence and report ----------------
  initial begin
    test_reset();
    test_streaming();
    test_back_pressure();
    test_stall_release();
    test_drain();
    test_reset_mid();
    test_wrap();
    total++;
    if (rd_err) begin bad++; $display("FAIL rd_error got=1 want=0"); end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog got=timeout want=finish");
    $fatal(1, "watchdog");
  end

endmodule
